// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer: tracks the FIFO's one-cycle read latency and buffers returned words into a 3-entry valid/ready stream
module fifo_read_streamer #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_dout,
    output logic                  fifo_ren,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [1:0]            buf_level,
    output logic [CNT_WIDTH-1:0]  word_count
);
    logic [FIFO_WIDTH-1:0] buffer [3];
    logic [1:0] head;
    logic [1:0] tail;
    logic [1:0] buf_count;
    logic inflight;
    logic pop;
    logic [2:0] occupancy;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return p == 2'd2 ? 2'd0 : p + 2'd1;
    endfunction

    // A read is issued only when a buffer slot is already reserved for its data
    assign occupancy = {1'b0, buf_count} + {2'b0, inflight};
    assign fifo_ren = rst_n && enable && !fifo_empty && (occupancy < 3'd3);
    assign m_valid = buf_count != 2'd0;
    assign m_data = buffer[head];
    assign pop = m_valid && m_ready;
    assign buf_level = buf_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer <= '{default: '0};
            head <= 2'd0;
            tail <= 2'd0;
            buf_count <= 2'd0;
            inflight <= 1'b0;
            word_count <= '0;
        end else begin
            if (inflight) begin
                buffer[tail] <= fifo_dout;
                tail <= inc3(tail);
            end
            if (pop) begin
                head <= inc3(head);
                word_count <= word_count + CNT_WIDTH'(1);
            end
            buf_count <= buf_count + {1'b0, inflight} - {1'b0, pop};
            inflight <= fifo_ren;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) occupancy <= 3'd3);
endmodule

// File: tb/tb_fifo_read_streamer.sv
// tb_fifo_read_streamer: directed and table-driven checks of fifo_read_streamer against a behavioural FIFO
module tb_fifo_read_streamer;
    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic fifo_empty;
    logic [15:0] fifo_dout = 16'h0;
    logic fifo_ren;
    logic [15:0] m_data;
    logic m_valid;
    logic m_ready;
    logic [1:0] buf_level;
    logic [15:0] word_count;
    logic fifo_ren4;
    logic [15:0] m_data4;
    logic m_valid4;
    logic [1:0] buf_level4;
    logic [3:0] wc4;
    logic fifo_clr = 1'b0;

    logic [15:0] mem [0:1023];
    int rd_ptr = 0;
    int wr_ptr = 0;
    int checks = 0;
    int failures = 0;
    int mon_ptr;
    int mon_end;
    logic prev_stall;
    logic [15:0] prev_data;

    typedef struct {
        logic rdy;
        logic ren;
        logic vld;
        logic [15:0] data;
        logic [1:0] lvl;
    } vec_t;
    vec_t bp [17];

    always #5 clk = ~clk;

    fifo_read_streamer #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_ren(fifo_ren), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .buf_level(buf_level), .word_count(word_count)
    );

    // Narrow-counter twin on identical inputs, used to observe word_count wrap
    fifo_read_streamer #(.FIFO_WIDTH(16), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_ren(fifo_ren4), .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
        .buf_level(buf_level4), .word_count(wc4)
    );

    assign fifo_empty = rd_ptr == wr_ptr;

    always @(posedge clk) begin
        if (fifo_clr) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_ren && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = base + 16'(i);
            wr_ptr++;
        end
    endtask

    task automatic mon_step();
        chk("occupancy_le3", 32'(({1'b0, buf_level} + {2'b0, dut.inflight}) <= 3'd3), 32'd1);
        if (prev_stall) begin
            chk("stable_valid", 32'(m_valid), 32'd1);
            chk("stable_data", 32'(m_data), 32'(prev_data));
        end
        if (m_valid && m_ready) begin
            if (mon_ptr < mon_end) begin
                chk("beat_data", 32'(m_data), 32'(mem[mon_ptr]));
            end else begin
                checks++;
                failures++;
                $display("FAIL extra_beat: got %0h expected no beat at %0t", m_data, $time);
            end
            mon_ptr++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data = m_data;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bp[0]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 2'd0};
        bp[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 2'd0};
        bp[2]  = '{1'b0, 1'b1, 1'b1, 16'h0100, 2'd1};
        bp[3]  = '{1'b0, 1'b0, 1'b1, 16'h0100, 2'd2};
        bp[4]  = '{1'b0, 1'b0, 1'b1, 16'h0100, 2'd3};
        bp[5]  = '{1'b0, 1'b0, 1'b1, 16'h0100, 2'd3};
        bp[6]  = '{1'b1, 1'b0, 1'b1, 16'h0100, 2'd3};
        bp[7]  = '{1'b1, 1'b1, 1'b1, 16'h0101, 2'd2};
        bp[8]  = '{1'b1, 1'b1, 1'b1, 16'h0102, 2'd1};
        bp[9]  = '{1'b1, 1'b1, 1'b1, 16'h0103, 2'd1};
        bp[10] = '{1'b1, 1'b1, 1'b1, 16'h0104, 2'd1};
        bp[11] = '{1'b1, 1'b1, 1'b1, 16'h0105, 2'd1};
        bp[12] = '{1'b1, 1'b1, 1'b1, 16'h0106, 2'd1};
        bp[13] = '{1'b1, 1'b1, 1'b1, 16'h0107, 2'd1};
        bp[14] = '{1'b1, 1'b0, 1'b1, 16'h0108, 2'd1};
        bp[15] = '{1'b1, 1'b0, 1'b1, 16'h0109, 2'd1};
        bp[16] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd0};

        rst_n = 1'b0;
        enable = 1'b1;
        m_ready = 1'b1;
        prev_stall = 1'b0;
        prev_data = 16'h0;
        preload(16'h0000, 16);
        repeat (3) begin
            @(negedge clk);
            chk("rst_ren", 32'(fifo_ren), 32'd0);
            chk("rst_valid", 32'(m_valid), 32'd0);
            chk("rst_data", 32'(m_data), 32'd0);
            chk("rst_wc", 32'(word_count), 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stream_ren", 32'(fifo_ren), 32'(i < 16));
            chk("stream_valid", 32'(m_valid), 32'(i >= 2 && i < 18));
            if (i >= 2 && i < 18) chk("stream_data", 32'(m_data), 32'(i - 2));
            @(posedge clk);
            #1;
        end
        chk("stream_wc", 32'(word_count), 32'd16);
        chk("stream_wc4", 32'(wc4), 32'd0);

        preload(16'h0E00, 4);
        @(negedge clk);
        chk("en_ren0", 32'(fifo_ren), 32'd1);
        @(posedge clk);
        #1 enable = 1'b0;
        for (int j = 1; j < 7; j++) begin
            @(negedge clk);
            chk("en_ren_off", 32'(fifo_ren), 32'd0);
            chk("en_valid", 32'(m_valid), 32'(j == 2));
            if (j == 2) chk("en_data", 32'(m_data), 32'h0E00);
            @(posedge clk);
            #1;
        end
        chk("en_wc", 32'(word_count), 32'd17);
        chk("wrap_wc4", 32'(wc4), 32'd1);
        enable = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain_wc", 32'(word_count), 32'd20);

        m_ready = 1'b0;
        preload(16'h0100, 10);
        for (int i = 0; i < 17; i++) begin
            m_ready = bp[i].rdy;
            @(negedge clk);
            chk("bp_ren", 32'(fifo_ren), 32'(bp[i].ren));
            chk("bp_valid", 32'(m_valid), 32'(bp[i].vld));
            if (bp[i].vld) chk("bp_data", 32'(m_data), 32'(bp[i].data));
            chk("bp_level", 32'(buf_level), 32'(bp[i].lvl));
            @(posedge clk);
            #1;
        end
        chk("bp_wc", 32'(word_count), 32'd30);

        mon_ptr = wr_ptr;
        preload(16'h2000, 200);
        mon_end = wr_ptr;
        prev_stall = 1'b0;
        for (int c = 0; c < 3000 && mon_ptr < mon_end; c++) begin
            @(posedge clk);
            #1 m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            mon_step();
        end
        chk("random_done", 32'(mon_ptr), 32'(mon_end));
        @(posedge clk);
        #1 m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("random_wc", 32'(word_count), 32'd230);
        chk("random_wc4", 32'(wc4), 32'd6);
        chk("random_idle", 32'(m_valid), 32'd0);

        m_ready = 1'b0;
        preload(16'h3000, 6);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_level", 32'(buf_level), 32'd2);
        chk("pre_rst_inflight", 32'(dut.inflight), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(m_valid), 32'd0);
        chk("async_rst_level", 32'(buf_level), 32'd0);
        chk("async_rst_ren", 32'(fifo_ren), 32'd0);
        chk("async_rst_data", 32'(m_data), 32'd0);
        chk("async_rst_wc", 32'(word_count), 32'd0);
        fifo_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1 fifo_clr = 1'b0;
        rst_n = 1'b1;
        mon_ptr = wr_ptr;
        preload(16'hB000, 5);
        mon_end = wr_ptr;
        m_ready = 1'b1;
        prev_stall = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            mon_step();
        end
        chk("post_rst_done", 32'(mon_ptr), 32'(mon_end));
        chk("post_rst_wc", 32'(word_count), 32'd5);
        chk("post_rst_wc4", 32'(wc4), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_read_streamer.md
# fifo_read_streamer

Read-side adapter for the dual-clock FIFO, living entirely in the read clock domain. It drives the FIFO's read enable, tracks the FIFO's one-cycle registered read latency and captures returned words into a 3-entry output buffer. It presents them as a valid/ready stream with full throughput and no combinational path from `m_ready` to `fifo_ren`.

## Interface
Parameters:
- `FIFO_WIDTH`, 16, data word width; must match the FIFO instance.
- `CNT_WIDTH`, 16, width of the delivered-word counter.

Ports:
- `clk`  in  1  read-domain clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  permits new FIFO reads while high.
- `fifo_empty`  in  1  FIFO empty flag (read domain).
- `fifo_dout`  in  FIFO_WIDTH  FIFO registered read data.
- `fifo_ren`  out  1  FIFO read enable.
- `m_data`  out  FIFO_WIDTH  stream data.
- `m_valid`  out  1  stream data valid.
- `m_ready`  in  1  downstream accepts.
- `buf_level`  out  2  buffered words, 0..3.
- `word_count`  out  CNT_WIDTH  words delivered since reset.

## Operation
- FIFO contract:
  - A read is accepted at an edge where `fifo_ren && !fifo_empty`.
  - `fifo_dout` shows that word after the same edge.
  - `fifo_dout` holds until the next accepted read.
- State:
  - 3-entry circular buffer: head/tail pointers, each 2 bits modulo 3.
  - `buf_count` (0..3).
  - `inflight` flag (1 bit).
- Read issue, combinational from registered state only:
  - `fifo_ren = rst_n && enable && !fifo_empty && (buf_count + inflight < 3)`.
- `inflight` next value = `fifo_ren && !fifo_empty`.
- Capture: at any edge where `inflight` is 1, `fifo_dout` is written at tail and tail advances.
- Pop: at any edge where `m_valid && m_ready`, head advances and `word_count` increments.
  - `word_count` wraps modulo 2^CNT_WIDTH.
- Capture and pop at the same edge: `buf_count` unchanged, both pointers advance.
- `m_valid = (buf_count != 0)`, `m_data = buffer[head]`.
  - Both are driven from registers, with no path from any input.
- Stream rules:
  - While `m_valid && !m_ready`, `m_data` and `m_valid` hold stable.
  - `m_valid` never drops without a pop.
- `enable` low:
  - No new reads are issued.
  - An in-flight word is still captured.
  - Buffered words still drain.
- Overflow is impossible by construction, since a read is issued only when a slot is reserved for it.
  - `buf_count + inflight` never exceeds 3; assert this in simulation.
- Reset:
  - Asserting `rst_n` low at any time clears buffer count, pointers, `inflight`, `word_count`, and `m_data` (to 0).
  - Any in-flight or buffered words are discarded.
  - The system resets the FIFO and this block together.

## Timing
- Reset values: `fifo_ren` 0, `m_valid` 0, `m_data` 0, `buf_level` 0, `word_count` 0.
- Latency, starting from empty with `m_ready` high:
  - Read accepted at edge E0; `fifo_dout` valid after E0.
  - Word captured at E1; `m_valid` high after E1.
  - Popped at E2.
  - First-word latency is two edges from the accepted read.
- Throughput: one word per clock sustained when the FIFO is non-empty and `m_ready` is held high.
  - Steady state: `buf_count` = 1 and `inflight` = 1 each cycle.
- Backpressure: after `m_ready` falls, at most 3 words accumulate (`buf_level` = 3), then `fifo_ren` stays 0.
  - When `m_ready` rises, reads resume the cycle after the first pop lowers `buf_count + inflight` below 3.
- `fifo_empty` rising: reads stop that cycle; an already accepted word is still captured at the next edge.

## Test plan
- Reset/idle:
  - Hold `rst_n` low 3 cycles with the FIFO holding data.
  - Require `fifo_ren`=0, `m_valid`=0, `m_data`=0, `word_count`=0.
  - After release with `enable`=1, require `fifo_ren`=1 on the first cycle.
- Streaming:
  - Preload the FIFO with 16 words 0x0000..0x000F; hold `m_ready`=1.
  - Require `m_valid` two edges after the first read, then 16 consecutive beats in order.
  - Require `word_count`=16 and then `fifo_ren`=0 when empty.
- Backpressure:
  - Preload 10 words; hold `m_ready`=0.
  - Require exactly 3 reads, `buf_level`=3, `m_data`=first word held stable.
  - Raise `m_ready`; require all 10 words in order with no gaps after the pipeline refills.
- Random `m_ready` at 50% duty with 200 words:
  - Require in-order, lossless, duplicate-free delivery.
  - Require the stability rule never violated and `buf_count + inflight` ≤ 3.
- Enable/empty edges:
  - Drop `enable` the cycle a read is accepted; require that word still delivered and no further reads.
  - Wrap `word_count` with CNT_WIDTH=4 after 17 words; require value 1.
- Reset mid-stream:
  - Assert `rst_n` low asynchronously (mid-cycle) with `buf_level`=2 and `inflight`=1.
  - Require immediate `m_valid`=0 and `buf_level`=0.
  - After release, require no stale words emitted.
